// File: rtl/d_e_pipe_reg_pkg.sv
// Shared pipeline definitions: instruction-class width, Tnew encodings,
// the default reset PC and the registered D->E bundle layout.
package d_e_pipe_reg_pkg;

  localparam int          INSTR_TYPE_W     = 10;
  localparam logic [1:0]  TNEW_0           = 2'd0;
  localparam logic [1:0]  TNEW_1           = 2'd1;
  localparam logic [1:0]  TNEW_2           = 2'd2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic [31:0]             pc;
    logic [31:0]             instr;
    logic [INSTR_TYPE_W-1:0] instr_type;
    logic [31:0]             rs_data;
    logic [31:0]             rt_data;
    logic [31:0]             ext;
    logic [4:0]              wr_num;
    logic                    wr_en;
    logic [1:0]              tnew;
    logic                    valid;
  } e_bundle_t;

  // A NOP in E: everything cleared except the PC, which is kept for exceptions.
  function automatic e_bundle_t nop_bundle(input logic [31:0] pc);
    e_bundle_t b;
    b    = '0;
    b.pc = pc;
    return b;
  endfunction

endpackage

// File: rtl/d_e_pipe_reg_sat_counter.sv
// Saturating up-counter with async active-high reset; reused for the
// per-stage bubble counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/d_e_pipe_reg.sv
// D->E pipeline register: captures the decoded bundle, or loads a NOP when
// the stall unit asks for a bubble. All outputs come straight from flops.
module d_e_pipe_reg
  import d_e_pipe_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    E_REG_STALL,
  input  logic [31:0]             D_PC,
  input  logic [31:0]             D_inStr,
  input  logic [INSTR_TYPE_W-1:0] D_inStrType,
  input  logic [31:0]             D_rsData,
  input  logic [31:0]             D_rtData,
  input  logic [31:0]             D_ext,
  input  logic [4:0]              D_writeReg_NUM,
  input  logic                    D_writeReg_EN,
  input  logic [1:0]              D_TnewE,
  output logic [31:0]             E_PC,
  output logic [31:0]             E_inStr,
  output logic [INSTR_TYPE_W-1:0] E_inStrType,
  output logic [31:0]             E_rsData,
  output logic [31:0]             E_rtData,
  output logic [31:0]             E_ext,
  output logic [4:0]              E_writeReg_NUM,
  output logic                    E_writeReg_EN,
  output logic [1:0]              E_Tnew,
  output logic                    E_valid,
  output logic [CNT_W-1:0]        bubble_cnt
);

  e_bundle_t e_d, e_q;

  always_comb begin
    e_d = nop_bundle(D_PC);
    if (!E_REG_STALL) begin
      e_d.instr      = D_inStr;
      e_d.instr_type = D_inStrType;
      e_d.rs_data    = D_rsData;
      e_d.rt_data    = D_rtData;
      e_d.ext        = D_ext;
      e_d.wr_num     = D_writeReg_NUM;
      // $0 is hardwired, so never advertise a pending write to it.
      e_d.wr_en      = D_writeReg_EN && (D_writeReg_NUM != 5'd0);
      e_d.tnew       = D_TnewE;
      e_d.valid      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) e_q <= nop_bundle(RESET_PC);
    else       e_q <= e_d;
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (E_REG_STALL),
    .count (bubble_cnt)
  );

  assign E_PC           = e_q.pc;
  assign E_inStr        = e_q.instr;
  assign E_inStrType    = e_q.instr_type;
  assign E_rsData       = e_q.rs_data;
  assign E_rtData       = e_q.rt_data;
  assign E_ext          = e_q.ext;
  assign E_writeReg_NUM = e_q.wr_num;
  assign E_writeReg_EN  = e_q.wr_en;
  assign E_Tnew         = e_q.tnew;
  assign E_valid        = e_q.valid;

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// Directed bench for d_e_pipe_reg: scoreboard of expected E bundles plus
// models of the bubble counter at two widths (16 and 4 bits).
module tb_d_e_pipe_reg;
  import d_e_pipe_reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_REG_STALL;
  logic [31:0] D_PC, D_inStr, D_rsData, D_rtData, D_ext;
  logic [9:0]  D_inStrType;
  logic [4:0]  D_writeReg_NUM;
  logic        D_writeReg_EN;
  logic [1:0]  D_TnewE;

  logic [31:0] E_PC, E_inStr, E_rsData, E_rtData, E_ext;
  logic [9:0]  E_inStrType;
  logic [4:0]  E_writeReg_NUM;
  logic        E_writeReg_EN, E_valid;
  logic [1:0]  E_Tnew;
  logic [15:0] bubble_cnt;

  logic [31:0] s_PC, s_inStr, s_rsData, s_rtData, s_ext;
  logic [9:0]  s_inStrType;
  logic [4:0]  s_writeReg_NUM;
  logic        s_writeReg_EN, s_valid;
  logic [1:0]  s_Tnew;
  logic [3:0]  s_bubble_cnt;

  d_e_pipe_reg dut (
    .clk(clk), .reset(reset), .E_REG_STALL(E_REG_STALL),
    .D_PC(D_PC), .D_inStr(D_inStr), .D_inStrType(D_inStrType),
    .D_rsData(D_rsData), .D_rtData(D_rtData), .D_ext(D_ext),
    .D_writeReg_NUM(D_writeReg_NUM), .D_writeReg_EN(D_writeReg_EN), .D_TnewE(D_TnewE),
    .E_PC(E_PC), .E_inStr(E_inStr), .E_inStrType(E_inStrType),
    .E_rsData(E_rsData), .E_rtData(E_rtData), .E_ext(E_ext),
    .E_writeReg_NUM(E_writeReg_NUM), .E_writeReg_EN(E_writeReg_EN),
    .E_Tnew(E_Tnew), .E_valid(E_valid), .bubble_cnt(bubble_cnt)
  );

  d_e_pipe_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .E_REG_STALL(E_REG_STALL),
    .D_PC(D_PC), .D_inStr(D_inStr), .D_inStrType(D_inStrType),
    .D_rsData(D_rsData), .D_rtData(D_rtData), .D_ext(D_ext),
    .D_writeReg_NUM(D_writeReg_NUM), .D_writeReg_EN(D_writeReg_EN), .D_TnewE(D_TnewE),
    .E_PC(s_PC), .E_inStr(s_inStr), .E_inStrType(s_inStrType),
    .E_rsData(s_rsData), .E_rtData(s_rtData), .E_ext(s_ext),
    .E_writeReg_NUM(s_writeReg_NUM), .E_writeReg_EN(s_writeReg_EN),
    .E_Tnew(s_Tnew), .E_valid(s_valid), .bubble_cnt(s_bubble_cnt)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_fail   = 0;
  int        cnt_main = 0;
  int        cnt_sat  = 0;
  e_bundle_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bundle(input string tag, input e_bundle_t obs, input e_bundle_t exp);
    check({tag, ".pc"},     obs.pc,               exp.pc);
    check({tag, ".instr"},  obs.instr,            exp.instr);
    check({tag, ".type"},   32'(obs.instr_type),  32'(exp.instr_type));
    check({tag, ".rs"},     obs.rs_data,          exp.rs_data);
    check({tag, ".rt"},     obs.rt_data,          exp.rt_data);
    check({tag, ".ext"},    obs.ext,              exp.ext);
    check({tag, ".wr_num"}, 32'(obs.wr_num),      32'(exp.wr_num));
    check({tag, ".wr_en"},  32'(obs.wr_en),       32'(exp.wr_en));
    check({tag, ".tnew"},   32'(obs.tnew),        32'(exp.tnew));
    check({tag, ".valid"},  32'(obs.valid),       32'(exp.valid));
  endtask

  function automatic e_bundle_t observed();
    e_bundle_t o;
    o.pc = E_PC;           o.instr = E_inStr;        o.instr_type = E_inStrType;
    o.rs_data = E_rsData;  o.rt_data = E_rtData;     o.ext = E_ext;
    o.wr_num = E_writeReg_NUM; o.wr_en = E_writeReg_EN;
    o.tnew = E_Tnew;       o.valid = E_valid;
    return o;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, ".cnt16"}, 32'(bubble_cnt),   32'(cnt_main));
    check({tag, ".cnt4"},  32'(s_bubble_cnt), 32'(cnt_sat));
  endtask

  task automatic check_reset(input string tag);
    e_bundle_t exp;
    exp    = '0;
    exp.pc = 32'h0000_3000;
    check_bundle(tag, observed(), exp);
    check({tag, ".cnt16"}, 32'(bubble_cnt),   32'd0);
    check({tag, ".cnt4"},  32'(s_bubble_cnt), 32'd0);
  endtask

  // Drive one edge's worth of D inputs, predict E, then compare after the edge.
  task automatic step(input string tag, input logic stall, input logic [31:0] pc,
                      input logic [31:0] instr, input logic [9:0] typ,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] ext,
                      input logic [4:0] num, input logic en, input logic [1:0] tnew);
    e_bundle_t exp;
    E_REG_STALL = stall; D_PC = pc; D_inStr = instr; D_inStrType = typ;
    D_rsData = rs; D_rtData = rt; D_ext = ext;
    D_writeReg_NUM = num; D_writeReg_EN = en; D_TnewE = tnew;
    exp    = '0;
    exp.pc = pc;
    if (!stall) begin
      exp.instr = instr; exp.instr_type = typ; exp.rs_data = rs; exp.rt_data = rt;
      exp.ext = ext; exp.wr_num = num; exp.wr_en = en && (num != 5'd0);
      exp.tnew = tnew; exp.valid = 1'b1;
    end
    exp_q.push_back(exp);
    @(posedge clk);
    if (stall) begin
      if (cnt_main < 65535) cnt_main++;
      if (cnt_sat < 15)     cnt_sat++;
    end
    #1;
    check({tag, ".sb_depth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) check_bundle(tag, observed(), exp_q.pop_front());
    check_counts(tag);
  endtask

  task automatic step_rand(input string tag, input logic stall);
    step(tag, stall, $urandom, $urandom, 10'($urandom), $urandom, $urandom, $urandom,
         5'($urandom), 1'($urandom), 2'($urandom_range(0, 2)));
  endtask

  task automatic randomize_inputs();
    D_PC = $urandom; D_inStr = $urandom; D_inStrType = 10'($urandom);
    D_rsData = $urandom; D_rtData = $urandom; D_ext = $urandom;
    D_writeReg_NUM = 5'($urandom); D_writeReg_EN = 1'($urandom); D_TnewE = 2'($urandom);
  endtask

  // Called just after an edge: assert reset mid-cycle, check at once, release before next edge.
  task automatic mid_cycle_reset(input string tag);
    #2;
    reset = 1'b1;
    randomize_inputs();
    #1;
    check_reset(tag);
    exp_q.delete();
    cnt_main = 0;
    cnt_sat  = 0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    E_REG_STALL = 1'b0;
    randomize_inputs();
    #2;
    check_reset("por");
    #6;
    reset = 1'b0;

    step_rand("rand_cap0", 1'b0);
    step_rand("rand_cap1", 1'b0);
    step_rand("rand_bub0", 1'b1);
    step_rand("rand_cap2", 1'b0);

    mid_cycle_reset("mid_reset");

    step("lw_cap", 1'b0, 32'h0000_3004, 32'h8C41_0004, 10'b00_0000_0100,
         32'h1000_0000, 32'h0000_00AA, 32'h0000_0004, 5'd1, 1'b1, TNEW_2);
    step("zero_wr", 1'b0, 32'h0000_3008, 32'h8C40_0008, 10'b00_0000_0100,
         32'h1, 32'h2, 32'h8, 5'd0, 1'b1, TNEW_1);
    step("no_wr", 1'b0, 32'h0000_300C, 32'hAC41_0000, 10'b00_0000_1000,
         32'h3, 32'h4, 32'h0, 5'd7, 1'b0, TNEW_0);
    step("tnew3", 1'b0, 32'h0000_3010, 32'h0022_1820, 10'b00_0000_0001,
         32'h5, 32'h6, 32'h0, 5'd3, 1'b1, 2'd3);

    for (int i = 0; i < 3; i++)
      step($sformatf("bubble%0d", i), 1'b1, 32'h0000_3008, $urandom, 10'($urandom),
           $urandom, $urandom, $urandom, 5'd9, 1'b1, TNEW_2);
    check("bubble_cnt_eq3", 32'(bubble_cnt), 32'd3);

    step_rand("cap_after_bub", 1'b0);

    for (int i = 0; i < 20; i++) step_rand($sformatf("sat%0d", i), 1'b1);
    check("sat_cnt4_eq15", 32'(s_bubble_cnt), 32'd15);
    check("sat_cnt16_eq23", 32'(bubble_cnt), 32'd23);
    step_rand("cap_after_sat", 1'b0);
    check("sat_hold15", 32'(s_bubble_cnt), 32'd15);

    step_rand("pre_reset_bub", 1'b1);
    E_REG_STALL = 1'b1;
    mid_cycle_reset("stall_reset");
    step("post_reset_cap", 1'b0, 32'h0000_4000, 32'h2021_0001, 10'b00_0001_0000,
         32'h11, 32'h22, 32'h1, 5'd1, 1'b1, TNEW_1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_e_pipe_reg.md
# d_e_pipe_reg

D→E pipeline register of the five-stage MIPS core; sits directly downstream of the hazard stall unit and consumes its `E_REG_STALL` output.
- Normal cycles: captures the decoded D-stage instruction bundle (PC, instruction, type, forwarded operands, extended immediate, destination register, Tnew).
- Stall cycles: loads a bubble (a NOP) into E.
- Its E-stage outputs (`E_writeReg_NUM`, `E_writeReg_EN`, `E_Tnew`) feed straight back into the stall unit.
- Keeps a saturating bubble counter for performance debug.

## Interface
Reset is asynchronous and active-high, with one clock.
- `RESET_PC`, default 32'h0000_3000: value of `E_PC` after reset.
- `CNT_W`, default 16: width of the bubble counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `E_REG_STALL`  in  1  from stall unit; 1 = load a bubble this edge
- `D_PC`  in  32  PC of the D-stage instruction
- `D_inStr`  in  32  raw D-stage instruction word
- `D_inStrType`  in  10  one-hot instruction class
- `D_rsData`  in  32  forwarded rs operand
- `D_rtData`  in  32  forwarded rt operand
- `D_ext`  in  32  extended immediate
- `D_writeReg_NUM`  in  5  destination register number
- `D_writeReg_EN`  in  1  destination write enable
- `D_TnewE`  in  2  Tnew the instruction will have on entering E (0..2)
- `E_PC`, `E_inStr`, `E_rsData`, `E_rtData`, `E_ext`  out  32 each  registered copies of the D-stage inputs
- `E_inStrType`  out  10  registered copy of `D_inStrType`
- `E_writeReg_NUM`  out  5  registered destination register number
- `E_writeReg_EN`  out  1  registered destination write enable
- `E_Tnew`  out  2  registered Tnew
- `E_valid`  out  1  1 = real instruction, 0 = bubble or reset
- `bubble_cnt`  out  CNT_W  number of bubbles inserted since reset, saturating

## Operation
- Reset (async assert) clears every output immediately:
  - all data outputs = 0;
  - `E_PC` = `RESET_PC`;
  - `E_valid` = 0, `E_Tnew` = 0, `E_writeReg_EN` = 0;
  - `bubble_cnt` = 0.
- Capture (`E_REG_STALL`=0) copies every D input to its E output and sets `E_valid`=1.
  - Exception: `E_writeReg_EN` is set to `D_writeReg_EN && (D_writeReg_NUM != 0)`, so writes to $0 are never advertised.
- Bubble (`E_REG_STALL`=1) loads a NOP:
  - `E_inStr`, `E_inStrType`, both operands, `E_ext`, `E_writeReg_NUM` = 0;
  - `E_writeReg_EN` = 0, `E_Tnew` = 0, `E_valid` = 0;
  - `E_PC` = `D_PC`, kept for future exception-PC use.
- Bubble counter:
  - `bubble_cnt` increments by 1 on each bubble edge.
  - It saturates at all-ones and never wraps.
  - It is unaffected by capture edges.
- Implicit state machine per edge: VALID ⇄ BUBBLE, selected solely by `E_REG_STALL`. There is no multi-cycle memory; consecutive stall cycles each insert a fresh bubble.
- `D_TnewE` values outside 0..2 (i.e. 3) are passed through unmodified; the decoder guarantees these do not occur.

## Timing
- Latency is 1 cycle: an input present before edge N appears on the outputs after edge N.
- No combinational path from any input to any output; outputs are pure flops.
  - This breaks the stall loop: `E_REG_STALL` → E outputs → stall unit → `E_REG_STALL`.
- Stall held k cycles → k bubbles and `bubble_cnt` += k (until saturation).
- Reset asserted mid-stream:
  - outputs go to their reset values within the same cycle, without waiting for `clk`;
  - the first edge after deassert behaves as a normal capture/bubble edge.
- Stall and reset together: reset wins.

## Structure
- A shared pipeline package holds:
  - the instruction-type one-hot width (10);
  - Tnew encoding constants (`TNEW_0`, `TNEW_1`, `TNEW_2`);
  - the default `RESET_PC`.
- A natural sub-module is `sat_counter` (parameter `CNT_W`; inputs `clk`, `reset`, `inc`; output `count`). It is reusable for the M/W stage counters.
- The rest of the block is a flat always block with an asynchronous reset branch.

## Test plan
- Reset: assert `reset` mid-cycle with random inputs → outputs immediately at reset values: `E_PC`=0x00003000, `E_valid`=0, `bubble_cnt`=0.
- Capture: `E_REG_STALL`=0, `D_inStr`=0x8C410004 (lw), `D_writeReg_NUM`=1, `D_writeReg_EN`=1, `D_TnewE`=2 → next cycle `E_inStr`=0x8C410004, `E_writeReg_EN`=1, `E_Tnew`=2, `E_valid`=1.
- $0 write: `D_writeReg_NUM`=0, `D_writeReg_EN`=1 → `E_writeReg_EN`=0.
- Bubble: `D_PC`=0x3008, stall held 3 cycles → `E_inStr`=0, `E_valid`=0, `E_PC`=0x3008 for all 3 cycles, `bubble_cnt`=3.
- Saturation: `CNT_W`=4, stall held 20 cycles → `bubble_cnt` stops at 15; a following capture leaves it at 15.
- Stall then reset: during a stall, assert `reset` → `bubble_cnt`=0 and `E_PC`=0x00003000 immediately; after release with stall=0, the first edge captures normally.
